// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned NUM_DIGITS   = 4;
  localparam int unsigned VALUE_W      = DIGIT_W * NUM_DIGITS;

  localparam int unsigned SEC_ONES_MAX = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_ONES_MAX = 9;
  localparam int unsigned MIN_TENS_MAX = 5;

  // Next value of one BCD digit: clear wins, otherwise wrap to 0 past max.
  function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] digit,
                                                  input int unsigned         max,
                                                  input logic                inc,
                                                  input logic                clr);
    logic [DIGIT_W-1:0] r;
    r = digit;
    if (clr) begin
      r = '0;
    end else if (inc) begin
      r = (digit == DIGIT_W'(max)) ? '0 : DIGIT_W'(digit + DIGIT_W'(1));
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the time counter; carry ripples the enable to the next digit.
module bcd_digit_cntr
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  // Carry is the enable for the next digit in the same cycle.
  assign carry = inc && (digit == DIGIT_W'(MAX));

  // Digit register, restricted to 0..MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else begin
      digit <= bcd_next(digit, MAX, inc, clr);
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch: button sync/edge detect, run/pause FSM, prescaler, BCD chain, lap freeze.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 125_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_start,
  input  logic               btn_lap,
  input  logic               btn_clear,
  output logic [VALUE_W-1:0] value,
  output logic               running,
  output logic               lap_active,
  output logic               wrap
);

  localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam int unsigned BTN_N     = 3;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_LAP   = 1;
  localparam int unsigned BTN_CLEAR = 2;
  localparam logic [1:0]  SETTLED   = 2'd3;

  logic [BTN_N-1:0]   sync_a, sync_b, sync_prev, evt;
  logic [1:0]         settle;
  logic               clr_act, start_act, lap_act;
  state_t             state, state_next;
  logic               lap_next, do_clear, lap_load;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [DIGIT_W-1:0] sec_ones, sec_tens, min_ones, min_tens;
  logic               c_so, c_st, c_mo, c_mt;
  logic [VALUE_W-1:0] live, live_next, lap_reg;

  // 2-FF synchroniser, edge detector and registered event pulses; events are
  // masked until the edge history is valid so a button held through reset is silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a    <= '0;
      sync_b    <= '0;
      sync_prev <= '0;
      settle    <= '0;
      evt       <= '0;
    end else begin
      sync_a    <= {btn_clear, btn_lap, btn_start};
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      if (settle != SETTLED) settle <= settle + 2'd1;
      evt       <= (settle == SETTLED) ? (sync_b & ~sync_prev) : '0;
    end
  end

  // Priority resolution: clear > start > lap, lower ones are dropped.
  assign clr_act   = evt[BTN_CLEAR];
  assign start_act = evt[BTN_START] && !evt[BTN_CLEAR];
  assign lap_act   = evt[BTN_LAP] && !evt[BTN_START] && !evt[BTN_CLEAR];

  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state, lap toggle and clear decode.
  always_comb begin
    state_next = state;
    lap_next   = lap_active;
    do_clear   = 1'b0;
    lap_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_act) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (start_act) begin
          state_next = ST_PAUSE;
        end else if (lap_act) begin
          lap_next = !lap_active;
          lap_load = !lap_active;
        end
      end
      ST_PAUSE: begin
        if (clr_act) begin
          state_next = ST_IDLE;
          lap_next   = 1'b0;
          do_clear   = 1'b1;
        end else if (start_act) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Prescaler: counts in RUN, holds in PAUSE, zero in IDLE or on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (do_clear || state == ST_IDLE) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : PRESC_W'(presc + PRESC_W'(1));
    end
  end

  bcd_digit_cntr #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .reset_n(reset_n), .inc(tick), .clr(do_clear), .digit(sec_ones), .carry(c_so));
  bcd_digit_cntr #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .reset_n(reset_n), .inc(c_so), .clr(do_clear), .digit(sec_tens), .carry(c_st));
  bcd_digit_cntr #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk(clk), .reset_n(reset_n), .inc(c_st), .clr(do_clear), .digit(min_ones), .carry(c_mo));
  bcd_digit_cntr #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .reset_n(reset_n), .inc(c_mo), .clr(do_clear), .digit(min_tens), .carry(c_mt));

  // Current digits and the digits after this edge, so value tracks without lag.
  assign live      = {min_tens, min_ones, sec_tens, sec_ones};
  assign live_next = {bcd_next(min_tens, MIN_TENS_MAX, c_mo, do_clear),
                      bcd_next(min_ones, MIN_ONES_MAX, c_st, do_clear),
                      bcd_next(sec_tens, SEC_TENS_MAX, c_so, do_clear),
                      bcd_next(sec_ones, SEC_ONES_MAX, tick, do_clear)};

  // Registered outputs, lap snapshot (pre-increment digits) and display mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_reg    <= '0;
      value      <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if (lap_load) lap_reg <= live;
      value      <= lap_next ? (lap_load ? live : lap_reg) : live_next;
      running    <= (state_next == ST_RUN);
      lap_active <= lap_next;
      wrap       <= c_mt;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd with TICK_CYCLES=4.
module tb_stopwatch_bcd;

  localparam int unsigned TICK = 4;
  localparam logic [2:0] B_S = 3'b001;
  localparam logic [2:0] B_L = 3'b010;
  localparam logic [2:0] B_C = 3'b100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start, btn_lap, btn_clear;
  logic [15:0] value;
  logic        running, lap_active, wrap;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  stopwatch_bcd #(.TICK_CYCLES(TICK)) dut (
    .clk(clk), .reset_n(reset_n), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .value(value), .running(running),
    .lap_active(lap_active), .wrap(wrap));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: got 0x%0h expected nothing queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, obs, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive buttons just after an edge; the action lands on the 4th edge.
  task automatic press(input logic [2:0] m);
    {btn_clear, btn_lap, btn_start} = m;
    step(4);
    {btn_clear, btn_lap, btn_start} = 3'b000;
  endtask

  initial begin
    reset_n = 1'b0;
    {btn_clear, btn_lap, btn_start} = 3'b000;
    step(2);
    sb_push("rst_value", 0); sb_push("rst_running", 0);
    sb_push("rst_lap", 0);   sb_push("rst_wrap", 0);
    sb_pop(32'(value)); sb_pop(32'(running)); sb_pop(32'(lap_active)); sb_pop(32'(wrap));
    reset_n = 1'b1;
    step(5);

    // Start: RUN entered at edge E.
    sb_push("start_running", 1); sb_push("start_value", 0);
    press(B_S);
    sb_pop(32'(running)); sb_pop(32'(value));
    sb_push("e3_value", 0);        step(3);  sb_pop(32'(value));
    sb_push("e4_value", 16'h0001); step(1);  sb_pop(32'(value));
    sb_push("e40_value", 16'h0010); step(36); sb_pop(32'(value));

    // Rollover at E+14400.
    sb_push("pre_wrap_value", 16'h5959); sb_push("pre_wrap_wrap", 0);
    step(14356); sb_pop(32'(value)); sb_pop(32'(wrap));
    sb_push("wrap_low_before", 0); step(3); sb_pop(32'(wrap));
    sb_push("wrap_value", 16'h0000); sb_push("wrap_pulse", 1);
    step(1); sb_pop(32'(value)); sb_pop(32'(wrap));
    sb_push("wrap_low_after", 0); step(1); sb_pop(32'(wrap));
    sb_push("post_wrap_value", 16'h0001); step(3); sb_pop(32'(value));

    // Pause at 12 s with prescaler at 2, hold, then resume.
    step(42);
    sb_push("pause_running", 0); sb_push("pause_value", 16'h0012);
    press(B_S);
    sb_pop(32'(running)); sb_pop(32'(value));
    sb_push("pause_hold", 16'h0012); step(100); sb_pop(32'(value));
    sb_push("resume_running", 1); sb_push("resume_value", 16'h0012);
    press(B_S);
    sb_pop(32'(running)); sb_pop(32'(value));
    sb_push("resume_r1", 16'h0012); step(1); sb_pop(32'(value));
    sb_push("resume_r2", 16'h0013); step(1); sb_pop(32'(value));

    // Pause at 30 s, then clear+start together in PAUSE.
    step(65);
    sb_push("pause30_running", 0); sb_push("pause30_value", 16'h0030);
    press(B_S);
    sb_pop(32'(running)); sb_pop(32'(value));
    step(3);
    sb_push("clr_running", 0); sb_push("clr_value", 0); sb_push("clr_lap", 0);
    press(B_S | B_C);
    sb_pop(32'(running)); sb_pop(32'(value)); sb_pop(32'(lap_active));
    step(3);

    // Restart from IDLE at E3; clear in RUN must be ignored.
    sb_push("restart_running", 1); sb_push("restart_value", 0);
    press(B_S);
    sb_pop(32'(running)); sb_pop(32'(value));
    step(2);
    sb_push("run_clr_running", 1); sb_push("run_clr_value", 16'h0001);
    press(B_C);
    sb_pop(32'(running)); sb_pop(32'(value));

    // Lap freeze at 7 s, five ticks underneath, then release at 12 s.
    step(20);
    sb_push("lap_on", 1); sb_push("lap_value", 16'h0007);
    press(B_L);
    sb_pop(32'(lap_active)); sb_pop(32'(value));
    sb_push("lap_frozen", 16'h0007); sb_push("lap_still_on", 1);
    step(15); sb_pop(32'(value)); sb_pop(32'(lap_active));
    sb_push("lap_off", 0); sb_push("lap_release_value", 16'h0012);
    press(B_L);
    sb_pop(32'(lap_active)); sb_pop(32'(value));
    sb_push("live_after_lap", 16'h0013); step(3); sb_pop(32'(value));

    // Freeze at 02:45, then async reset mid-cycle with start held.
    step(605);
    sb_push("lap245_on", 1); sb_push("lap245_value", 16'h0245);
    press(B_L);
    sb_pop(32'(lap_active)); sb_pop(32'(value));
    step(1);
    btn_start = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    sb_push("async_value", 0); sb_push("async_running", 0);
    sb_push("async_lap", 0);   sb_push("async_wrap", 0);
    sb_pop(32'(value)); sb_pop(32'(running)); sb_pop(32'(lap_active)); sb_pop(32'(wrap));
    step(3);
    reset_n = 1'b1;
    sb_push("held_running", 0); sb_push("held_value", 0);
    step(10); sb_pop(32'(running)); sb_pop(32'(value));
    btn_start = 1'b0;
    step(4);
    sb_push("post_rst_running", 1);
    press(B_S);
    sb_pop(32'(running));

    check_val("sb_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
